// File: rtl/fetch_assembler_if.sv
// Fetch port bundle: consumer-side controls, byte-ROM strobe/address/data and the instruction word handshake.
// master = fetch_assembler, slave = consumer/ROM environment.
interface fetch_assembler_if;
  logic        run;
  logic        pc_load;
  logic [31:0] pc_in;
  logic [31:0] addr;
  logic        trigger;
  logic [7:0]  data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  run, pc_load, pc_in, data, instr_ready,
    output addr, trigger, instr, instr_pc, instr_valid
  );

  modport slave (
    output run, pc_load, pc_in, data, instr_ready,
    input  addr, trigger, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_assembler.sv
// Byte-serial fetch: four toggle-strobed ROM reads build one little-endian word for a valid/ready port.
// Define FETCH_PREFETCH_EN to add a one-word skid buffer so fetching continues while the output waits.
module fetch_assembler #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  fetch_assembler_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, SAMPLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] addr_q, addr_d;
  logic        trigger_q, trigger_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        xfer;
  logic [31:0] word_w;
`ifdef FETCH_PREFETCH_EN
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
`endif

  assign xfer = instr_valid_q & bus.instr_ready;

  // Partial word with the byte arriving this cycle merged into lane k
  always_comb begin
    word_w = asm_q;
    word_w[{k_q, 3'b000} +: 8] = bus.data;
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    fpc_d         = fpc_q;
    addr_d        = addr_q;
    trigger_d     = trigger_q;
    asm_d         = asm_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_PREFETCH_EN
    buf_d         = buf_q;
    buf_pc_d      = buf_pc_q;
    buf_valid_d   = buf_valid_q;
`endif

    if (xfer) begin
      instr_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
      if (buf_valid_q) begin
        instr_d       = buf_q;
        instr_pc_d    = buf_pc_q;
        instr_valid_d = 1'b1;
        buf_valid_d   = 1'b0;
      end
`endif
    end

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = ADDR;
          k_d     = 2'd0;
        end
      end
      ADDR: state_d = SAMPLE;
      SAMPLE: begin
        asm_d = word_w;
        if (k_q != 2'd3) begin
          k_d     = k_q + 2'd1;
          state_d = bus.run ? ADDR : IDLE;
        end else begin
          k_d   = 2'd0;
          fpc_d = fpc_q + 32'd4;
`ifdef FETCH_PREFETCH_EN
          if (!instr_valid_d) begin
            instr_d       = word_w;
            instr_pc_d    = fpc_q;
            instr_valid_d = 1'b1;
          end else begin
            buf_d       = word_w;
            buf_pc_d    = fpc_q;
            buf_valid_d = 1'b1;
          end
          // Stall only once both output and buffer hold a word
          if (buf_valid_d)  state_d = HOLD;
          else if (bus.run) state_d = ADDR;
          else              state_d = IDLE;
`else
          instr_d       = word_w;
          instr_pc_d    = fpc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
`endif
        end
      end
      HOLD: begin
        if (xfer) begin
          k_d     = 2'd0;
          state_d = bus.run ? ADDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.pc_load) begin
      fpc_d         = bus.pc_in & ~32'd3;
      k_d           = 2'd0;
      asm_d         = '0;
      instr_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_valid_d   = 1'b0;
`endif
      // A redirect landing on ADDR detours through IDLE so trigger never toggles on back-to-back edges
      state_d = (bus.run && state_q != ADDR) ? ADDR : IDLE;
    end

    if (state_d == ADDR) begin
      addr_d    = fpc_d + {30'd0, k_d};
      trigger_d = ~trigger_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= 2'd0;
      fpc_q         <= RESET_PC;
      addr_q        <= RESET_PC;
      trigger_q     <= 1'b0;
      asm_q         <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_q         <= '0;
      buf_pc_q      <= '0;
      buf_valid_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      fpc_q         <= fpc_d;
      addr_q        <= addr_d;
      trigger_q     <= trigger_d;
      asm_q         <= asm_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_PREFETCH_EN
      buf_q         <= buf_d;
      buf_pc_q      <= buf_pc_d;
      buf_valid_q   <= buf_valid_d;
`endif
    end
  end

  assign bus.addr        = addr_q;
  assign bus.trigger     = trigger_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
endmodule

// File: tb/tb_fetch_assembler.sv
// Bench for fetch_assembler: byte-ROM model, stream-of-words scoreboard, directed scenarios then random traffic.
module tb_fetch_assembler;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
  localparam bit PREF = 1'b1;
`else
  localparam bit PREF = 1'b0;
`endif

  logic clk;
  logic rst;
  fetch_assembler_if bus();

  fetch_assembler #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ROM contents: fixed first word, hashed bytes elsewhere
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [31:0] first;
    first = 32'h1234_5678;
    if (a < 32'd4) return first[{a[1:0], 3'b000} +: 8];
    return a[7:0] ^ (a[15:8] * 8'd7) ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] p);
    return {rom_byte(p + 32'd3), rom_byte(p + 32'd2), rom_byte(p + 32'd1), rom_byte(p)};
  endfunction

  logic trig_seen = 1'b0;
  initial bus.data = 8'h00;
  always @(posedge clk) begin
    if (bus.trigger != trig_seen) bus.data <= rom_byte(bus.addr);
    trig_seen <= bus.trigger;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference: the word stream from the latest fetch origin
  logic [63:0] exp_q[$];
  logic [31:0] xfer_log[$];
  logic [31:0] addr_log[$];
  int          n_toggles = 0;

  task automatic load_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      p = start + 32'(4 * i);
      exp_q.push_back({p, rom_word(p)});
    end
  endtask

  logic last_trig = 1'b0;
  logic toggled_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      last_trig    = bus.trigger;
      toggled_prev = 1'b0;
    end else if (bus.trigger != last_trig) begin
      n_toggles++;
      addr_log.push_back(bus.addr);
      chk("trigger_spacing", 32'(toggled_prev), 32'd0);
      toggled_prev = 1'b1;
      last_trig    = bus.trigger;
    end else begin
      toggled_prev = 1'b0;
    end
  end

  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_pc_load = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_instr = '0, prev_pc = '0;
  logic [63:0] exp_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_valid && !prev_ready && !prev_pc_load && !prev_rst) begin
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold_instr", bus.instr, prev_instr);
        chk("hold_pc", bus.instr_pc, prev_pc);
      end
      if (prev_pc_load && !prev_rst) chk("redirect_valid_drop", 32'(bus.instr_valid), 32'd0);
      if (bus.instr_valid && bus.instr_ready) begin
        xfer_log.push_back(bus.instr_pc);
        if (exp_q.size() == 0) begin
          chk("sb_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_e = exp_q.pop_front();
          chk("sb_instr_pc", bus.instr_pc, exp_e[63:32]);
          chk("sb_instr", bus.instr, exp_e[31:0]);
        end
      end
    end
    prev_valid   = bus.instr_valid;
    prev_ready   = bus.instr_ready;
    prev_pc_load = bus.pc_load;
    prev_rst     = rst;
    prev_instr   = bus.instr;
    prev_pc      = bus.instr_pc;
  end

  // One cycle; a redirect issued for the previous cycle is retired and the stream restarted
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.pc_load) begin
      bus.pc_load = 1'b0;
      load_stream(bus.pc_in & ~32'd3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int          t0, t1, c0, a0, xs, n;
  logic [31:0] p_hold;

  initial begin
    rst = 1'b1;
    bus.run = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_in = '0;
    bus.instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", bus.addr, RST_PC);
    chk("rst_trigger", 32'(bus.trigger), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);

    // First word: latency, toggles, byte addresses, assembly
    load_stream(RST_PC);
    t0 = n_toggles;
    a0 = addr_log.size();
    rst = 1'b0;
    bus.run = 1'b1;
    step();
    chk("first_addr", bus.addr, RST_PC);
    chk("first_trigger", 32'(bus.trigger), 32'd1);
    c0 = cyc_cnt;
    for (int i = 0; i < 20 && !bus.instr_valid; i++) step();
    chk("first_valid_seen", 32'(bus.instr_valid), 32'd1);
    chk("first_latency", 32'(cyc_cnt - c0), 32'd8);
    chk("first_toggles", 32'(n_toggles - t0), 32'd4);
    for (int i = 0; i < 4; i++)
      if (addr_log.size() > a0 + i) chk("first_byte_addr", addr_log[a0 + i], RST_PC + 32'(i));
      else chk("first_byte_count", 32'(addr_log.size() - a0), 32'd4);
    chk("first_instr", bus.instr, 32'h1234_5678);
    chk("first_instr_pc", bus.instr_pc, RST_PC);

    // Backpressure for 20 cycles
    t1 = n_toggles;
    repeat (20) step();
    chk("stall_toggles", 32'(n_toggles - t1), PREF ? 32'd4 : 32'd0);
    chk("stall_instr", bus.instr, 32'h1234_5678);
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    step();
    chk("post_xfer_valid", 32'(bus.instr_valid), 32'(PREF));

    // Redirect during the byte-2 sample
    for (int i = 0; i < 40 && bus.addr[1:0] == 2'd2; i++) step();
    for (int i = 0; i < 40 && bus.addr[1:0] != 2'd2; i++) step();
    chk("find_byte2", 32'(bus.addr[1:0]), 32'd2);
    step();
    bus.pc_load = 1'b1;
    bus.pc_in = 32'h0000_0103;
    n = addr_log.size();
    step();
    for (int i = 0; i < 20 && addr_log.size() < n + 4; i++) step();
    chk("redir_addr_count", 32'(addr_log.size() >= n + 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (addr_log.size() > n + i) chk("redir_addr_seq", addr_log[n + i], 32'h100 + 32'(i));
    xs = xfer_log.size();
    for (int i = 0; i < 30 && xfer_log.size() <= xs; i++) step();
    if (xfer_log.size() > xs) chk("redir_instr_pc", xfer_log[xs], 32'h0000_0100);
    else chk("redir_xfer_seen", 32'(xfer_log.size() - xs), 32'd1);

    // Wrap of the fetch pointer
    bus.pc_load = 1'b1;
    bus.pc_in = 32'hFFFF_FFFC;
    step();
    xs = xfer_log.size();
    for (int i = 0; i < 60 && xfer_log.size() < xs + 2; i++) step();
    if (xfer_log.size() >= xs + 2) begin
      chk("wrap_pc0", xfer_log[xs], 32'hFFFF_FFFC);
      chk("wrap_pc1", xfer_log[xs + 1], 32'h0000_0000);
    end else chk("wrap_xfer_count", 32'(xfer_log.size() - xs), 32'd2);

    // Redirect coinciding with a transfer
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 30 && !bus.instr_valid; i++) step();
    chk("coinc_valid_seen", 32'(bus.instr_valid), 32'd1);
    p_hold = bus.instr_pc;
    xs = xfer_log.size();
    bus.instr_ready = 1'b1;
    bus.pc_load = 1'b1;
    bus.pc_in = 32'h0000_2000;
    step();
    chk("coinc_count", 32'(xfer_log.size() - xs), 32'd1);
    if (xfer_log.size() > xs) chk("coinc_pc", xfer_log[xs], p_hold);
    for (int i = 0; i < 30 && xfer_log.size() < xs + 2; i++) step();
    if (xfer_log.size() >= xs + 2) chk("coinc_next_pc", xfer_log[xs + 1], 32'h0000_2000);
    else chk("coinc_next_seen", 32'(xfer_log.size() - xs), 32'd2);

    // Asynchronous reset during the byte-1 address cycle
    for (int i = 0; i < 40 && bus.addr[1:0] == 2'd1; i++) step();
    for (int i = 0; i < 40 && bus.addr[1:0] != 2'd1; i++) step();
    chk("find_byte1", 32'(bus.addr[1:0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_addr", bus.addr, RST_PC);
    chk("mid_rst_trigger", 32'(bus.trigger), 32'd0);
    chk("mid_rst_instr", bus.instr, 32'd0);
    chk("mid_rst_instr_pc", bus.instr_pc, 32'd0);
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    load_stream(RST_PC);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    chk("restart_addr", bus.addr, RST_PC);
    chk("restart_trigger", 32'(bus.trigger), 32'd1);
    xs = xfer_log.size();
    for (int i = 0; i < 30 && xfer_log.size() <= xs; i++) step();
    if (xfer_log.size() > xs) chk("restart_pc", xfer_log[xs], RST_PC);
    else chk("restart_xfer_seen", 32'(xfer_log.size() - xs), 32'd1);

    // Random traffic against the stream model
    xs = xfer_log.size();
    for (int i = 0; i < 1500; i++) begin
      bus.run = ($urandom_range(0, 9) != 0);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) begin
        bus.pc_load = 1'b1;
        bus.pc_in = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      end
      step();
    end
    chk("random_progress", 32'(xfer_log.size() - xs >= 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
